// File: rtl/instr_fetch_if.sv
// Bus between the fetch stage, the control path and instruction memory.
// No latency of its own; wires only.
// mem_ready is the only memory-side flow control; pc_inc/redirect_en steer the fetcher.
interface instr_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              pc_inc;
  logic              redirect_en;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  logic [31:0]       instruction;
  logic              wait_instr;
  logic              instr_segv;
  logic [ADDR_W-1:0] pc;

  // Fetch stage side
  modport master (
    input  pc_inc, redirect_en, redirect_pc, mem_rdata, mem_ready,
    output mem_addr, mem_rd, instruction, wait_instr, instr_segv, pc
  );

  // Control path plus memory side
  modport slave (
    output pc_inc, redirect_en, redirect_pc, mem_rdata, mem_ready,
    input  mem_addr, mem_rd, instruction, wait_instr, instr_segv, pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: holds the PC, reads one word per instruction, presents it registered.
// Latency: pc_inc -> mem_rd 2 cycles, zero-wait memory -> wait_instr low 3 cycles after pc_inc.
// Backpressure: mem_rd/mem_addr held until mem_ready; optional FETCH_TIMEOUT_EN faults after TIMEOUT stalls.
module instr_fetch #(
  parameter int              ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [ADDR_W-1:0] INSTR_BASE  = '0,
  parameter logic [ADDR_W-1:0] INSTR_LIMIT = 32'h0001_0000,
  parameter int              TIMEOUT     = 16
) (
  input logic           clk,
  input logic           reset,
  instr_fetch_if.master bus
);

  typedef enum logic [2:0] {IDLE, CHECK, FETCH, VALID, FAULT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] pend_pc;
  logic              pend;
  logic [31:0]       instr_q;
  logic              mem_rd_q;
  logic              wait_q;
  logic              segv_q;
  logic              legal;

`ifdef FETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
`endif

  // Single unsigned compare covers both bounds: below-base addresses wrap to a huge offset.
  assign legal = (pc_q[1:0] == 2'b00) && ((pc_q - INSTR_BASE) < (INSTR_LIMIT - INSTR_BASE));

  // Fetch FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc_q       <= RESET_PC;
      mem_addr_q <= RESET_PC;
      pend_pc    <= '0;
      pend       <= 1'b0;
      instr_q    <= '0;
      mem_rd_q   <= 1'b0;
      wait_q     <= 1'b1;
      segv_q     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A stray mem_ready here belongs to a read killed by reset and is ignored.
          if (bus.redirect_en) pc_q <= bus.redirect_pc;
          state <= CHECK;
        end
        CHECK: begin
          if (bus.redirect_en) begin
            pc_q <= bus.redirect_pc;        // re-check the new target next cycle
          end else if (legal) begin
            state      <= FETCH;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= pc_q;
`ifdef FETCH_TIMEOUT_EN
            to_cnt     <= '0;
`endif
          end else begin
            state  <= FAULT;
            segv_q <= 1'b1;
          end
        end
        FETCH: begin
          if (bus.mem_ready) begin
            mem_rd_q <= 1'b0;
            if (bus.redirect_en) begin
              pc_q  <= bus.redirect_pc;     // newest redirect wins, read data dropped
              pend  <= 1'b0;
              state <= CHECK;
            end else if (pend) begin
              pc_q  <= pend_pc;
              pend  <= 1'b0;
              state <= CHECK;
            end else begin
              instr_q <= bus.mem_rdata;
              wait_q  <= 1'b0;
              state   <= VALID;
            end
          end else begin
            // The read in flight must complete; remember the redirect until then.
            if (bus.redirect_en) begin
              pend    <= 1'b1;
              pend_pc <= bus.redirect_pc;
            end
`ifdef FETCH_TIMEOUT_EN
            if (to_cnt == TO_W'(TIMEOUT - 1)) begin
              state    <= FAULT;
              segv_q   <= 1'b1;
              mem_rd_q <= 1'b0;
              pend     <= 1'b0;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
`endif
          end
        end
        VALID: begin
          if (bus.redirect_en) begin
            pc_q   <= bus.redirect_pc;
            wait_q <= 1'b1;
            state  <= CHECK;
          end else if (bus.pc_inc) begin
            pc_q   <= pc_q + ADDR_W'(4);
            wait_q <= 1'b1;
            state  <= CHECK;
          end
        end
        FAULT: begin
          if (bus.redirect_en) begin
            pc_q   <= bus.redirect_pc;
            segv_q <= 1'b0;
            state  <= CHECK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.instruction = instr_q;
  assign bus.wait_instr  = wait_q;
  assign bus.instr_segv  = segv_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model, scoreboard of expected {pc, instruction}, redirect table.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic reset;

  instr_fetch_if #(.ADDR_W(32)) bus ();

  instr_fetch #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] target; logic legal; int lat; } vec_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          mem_lat = 0;
  bit          mem_en = 1'b1;
  logic        ovr_ready = 1'b0;
  logic [31:0] ovr_data = '0;

  function automatic logic [31:0] memfun(input logic [31:0] a);
    return 32'hDEAD_BEEF ^ (a * 32'h0001_0001);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.addr = a;
    e.data = memfun(a);
    sb.push_back(e);
  endtask

  // Memory model: answers mem_ready after mem_lat stall cycles; override path when disabled.
  initial begin
    int rd_cycles;
    rd_cycles = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!mem_en) begin
        rd_cycles     = 0;
        bus.mem_ready = ovr_ready;
        bus.mem_rdata = ovr_data;
      end else if (bus.mem_rd) begin
        if (rd_cycles == mem_lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = memfun(bus.mem_addr);
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = 32'h0BAD_0BAD;
        end
        rd_cycles++;
      end else begin
        bus.mem_ready = 1'b0;
        rd_cycles     = 0;
      end
    end
  end

  // Scoreboard: every falling wait_instr must present the oldest expected instruction.
  initial begin
    logic prev_wait;
    exp_t e;
    prev_wait = 1'b1;
    forever begin
      @(negedge clk);
      if (prev_wait && !bus.wait_instr && !reset) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: got pc %h instr %h expected nothing", bus.pc, bus.instruction);
        end else begin
          e = sb.pop_front();
          check("sb_instr", bus.instruction, e.data);
          check("sb_pc", bus.pc, e.addr);
        end
      end
      prev_wait = bus.wait_instr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(output int edges, output bit saw_rd);
    edges  = 0;
    saw_rd = 1'b0;
    while (edges < 60) begin
      tick();
      edges++;
      if (bus.mem_rd) saw_rd = 1'b1;
      if (!bus.wait_instr || bus.instr_segv) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL settle_timeout: got no VALID/FAULT expected one within 60 cycles");
  endtask

  task automatic wait_rd();
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.mem_rd) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL wait_rd_timeout: got mem_rd=0 expected 1 within 30 cycles");
  endtask

  task automatic do_redirect(input logic [31:0] a, input bit also_inc);
    bus.redirect_en = 1'b1;
    bus.redirect_pc = a;
    bus.pc_inc      = also_inc;
    tick();
    bus.redirect_en = 1'b0;
    bus.pc_inc      = 1'b0;
  endtask

  task automatic pulse_inc();
    bus.pc_inc = 1'b1;
    tick();
    bus.pc_inc = 1'b0;
  endtask

  initial begin
    vec_t vec[9];
    int   edges;
    int   rd_cnt;
    int   addr_bad;
    int   wait_bad;
    bit   saw_rd;

    vec[0] = '{32'h0001_0000, 1'b0, 0};
    vec[1] = '{32'h0000_0100, 1'b1, 0};
    vec[2] = '{32'h0000_0102, 1'b0, 0};
    vec[3] = '{32'h0000_FFFC, 1'b1, 2};
    vec[4] = '{32'hFFFF_FFFC, 1'b0, 0};
    vec[5] = '{32'h0000_0001, 1'b0, 0};
    vec[6] = '{32'h0000_0080, 1'b1, 1};
    vec[7] = '{32'h0000_0000, 1'b1, 0};
    vec[8] = '{32'h0000_0008, 1'b1, 3};

    reset           = 1'b1;
    bus.pc_inc      = 1'b0;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", bus.pc, 32'h0);
    check("rst_instruction", bus.instruction, 32'h0);
    check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("rst_wait", 32'(bus.wait_instr), 32'd1);
    check("rst_segv", 32'(bus.instr_segv), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);

    // Reset release: IDLE, CHECK, FETCH with zero-wait memory -> VALID on the third edge.
    mem_lat = 0;
    push_exp(32'h0);
    reset = 1'b0;
    settle(edges, saw_rd);
    check("boot_latency", edges, 3);
    check("boot_mem_addr", bus.mem_addr, 32'h0);
    check("boot_instr", bus.instruction, 32'hDEAD_BEEF);

    // pc_inc with 4 stall cycles: request held at address 4 for 4 stalls plus the ready cycle.
    mem_lat = 4;
    push_exp(32'h4);
    pulse_inc();
    rd_cnt = 0; addr_bad = 0; wait_bad = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (!bus.wait_instr) break;
      if (bus.mem_rd) begin
        rd_cnt++;
        if (bus.mem_addr !== 32'h4) addr_bad++;
      end
    end
    check("stall_rd_cycles", rd_cnt, 5);
    check("stall_addr_stable", addr_bad, 0);
    check("stall_pc", bus.pc, 32'h4);

    // Minimum latency: CHECK at N+1, mem_rd at N+2, wait_instr low at N+3.
    mem_lat = 0;
    push_exp(32'h8);
    pulse_inc();
    check("lat_n1_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("lat_n1_wait", 32'(bus.wait_instr), 32'd1);
    tick();
    check("lat_n2_mem_rd", 32'(bus.mem_rd), 32'd1);
    check("lat_n2_mem_addr", bus.mem_addr, 32'h8);
    tick();
    check("lat_n3_wait", 32'(bus.wait_instr), 32'd0);

    // Redirect table: legal targets fetch, illegal ones fault without a read.
    foreach (vec[i]) begin
      mem_lat = vec[i].lat;
      if (vec[i].legal) push_exp(vec[i].target);
      do_redirect(vec[i].target, 1'b0);
      settle(edges, saw_rd);
      check($sformatf("vec%0d_segv", i), 32'(bus.instr_segv), 32'(!vec[i].legal));
      check($sformatf("vec%0d_mem_rd_seen", i), 32'(saw_rd), 32'(vec[i].legal));
      check($sformatf("vec%0d_pc", i), bus.pc, vec[i].target);
    end

    // redirect_en beats pc_inc in the same cycle.
    mem_lat = 0;
    push_exp(32'h40);
    do_redirect(32'h40, 1'b1);
    check("prio_pc", bus.pc, 32'h40);
    settle(edges, saw_rd);

    // Redirect mid-fetch: the stalled read completes and its data is dropped.
    mem_lat = 3;
    pulse_inc();
    wait_rd();
    push_exp(32'h200);
    do_redirect(32'h200, 1'b0);
    settle(edges, saw_rd);
    check("abort_pc", bus.pc, 32'h200);

    // Redirect on the mem_ready cycle itself.
    mem_lat = 0;
    pulse_inc();
    wait_rd();
    push_exp(32'h300);
    do_redirect(32'h300, 1'b0);
    settle(edges, saw_rd);
    check("abort_ready_pc", bus.pc, 32'h300);

    // pc_inc during FETCH is ignored.
    mem_lat = 3;
    push_exp(32'h304);
    pulse_inc();
    wait_rd();
    pulse_inc();
    settle(edges, saw_rd);
    check("ignored_inc_pc", bus.pc, 32'h304);

    // Reset mid-fetch drops mem_rd at once; a late mem_ready in IDLE is ignored.
    mem_lat = 10;
    pulse_inc();
    wait_rd();
    mem_en    = 1'b0;
    ovr_ready = 1'b1;
    ovr_data  = 32'h1BAD_1BAD;
    reset     = 1'b1;
    #1;
    check("rst_async_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("rst_async_pc", bus.pc, 32'h0);
    tick();
    tick();
    push_exp(32'h0);
    reset = 1'b0;
    tick();
    check("late_ready_instr", bus.instruction, 32'h0);
    check("late_ready_wait", 32'(bus.wait_instr), 32'd1);
    mem_lat   = 0;
    ovr_ready = 1'b0;
    mem_en    = 1'b1;
    settle(edges, saw_rd);
    check("late_ready_pc", bus.pc, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers: FAULT exactly TIMEOUT cycles after FETCH entry.
    mem_en    = 1'b0;
    ovr_ready = 1'b0;
    do_redirect(32'h500, 1'b0);
    wait_rd();
    edges = 0;
    while (edges < 40 && !bus.instr_segv) begin
      tick();
      edges++;
    end
    check("timeout_cycles", edges, 16);
    check("timeout_segv", 32'(bus.instr_segv), 32'd1);
    check("timeout_mem_rd", 32'(bus.mem_rd), 32'd0);
    mem_en = 1'b1;
    push_exp(32'h100);
    do_redirect(32'h100, 1'b0);
    settle(edges, saw_rd);
    check("timeout_recover_pc", bus.pc, 32'h100);
`endif

    repeat (3) tick();
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

endmodule
